// File: rtl/pm_fetch_sequencer.sv
// Program-memory fetch sequencer: owns the PC and assembles one- or two-byte
// instructions for execute over a valid/ready handshake.
`timescale 1ns/1ps
module pm_fetch_sequencer #(
    parameter logic [4:0] START_ADDR   = 5'd0,
    parameter bit         HALT_ON_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [4:0] pm_addr,
    input  logic [7:0] pm_data,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] instr_op,
    output logic [7:0] instr_imm,
    output logic [4:0] instr_pc,
    input  logic       redirect_valid,
    input  logic [4:0] redirect_addr,
    output logic       busy,
    output logic       halted
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_OP,
        FETCH_IMM,
        PRESENT,
        HALT
    } state_t;

    state_t     state, state_n;
    logic [4:0] pc, pc_n;
    logic       valid_n;
    logic [7:0] op_n, imm_n;
    logic [4:0] ipc_n;
    logic       two_byte;
    logic       active;

    assign two_byte = (pm_data[7:4] == 4'b0010) || (pm_data[7:4] == 4'b1101);
    assign active   = (state == FETCH_OP) || (state == FETCH_IMM) ||
                      (state == PRESENT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= START_ADDR;
            instr_valid <= 1'b0;
            instr_op    <= 8'h00;
            instr_imm   <= 8'h00;
            instr_pc    <= 5'd0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr_valid <= valid_n;
            instr_op    <= op_n;
            instr_imm   <= imm_n;
            instr_pc    <= ipc_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        valid_n = instr_valid;
        op_n    = instr_op;
        imm_n   = instr_imm;
        ipc_n   = instr_pc;
        unique case (state)
            IDLE, HALT: begin
                if (start) begin
                    pc_n    = START_ADDR;
                    state_n = FETCH_OP;
                end
            end
            FETCH_OP: begin
                op_n  = pm_data;
                ipc_n = pc;
                imm_n = 8'h00;
                pc_n  = pc + 5'd1;
                if (HALT_ON_ZERO && (pm_data == 8'h00)) begin
                    state_n = HALT;
                end else if (two_byte) begin
                    state_n = FETCH_IMM;
                end else begin
                    state_n = PRESENT;
                    valid_n = 1'b1;
                end
            end
            FETCH_IMM: begin
                imm_n   = pm_data;
                pc_n    = pc + 5'd1;
                state_n = PRESENT;
                valid_n = 1'b1;
            end
            PRESENT: begin
                if (instr_valid && instr_ready) begin
                    valid_n = 1'b0;
                    state_n = FETCH_OP;
                end
            end
            default: state_n = IDLE;
        endcase
        // A redirect overrides whatever the fetch was doing this cycle.
        if (redirect_valid && active) begin
            state_n = FETCH_OP;
            pc_n    = redirect_addr;
            valid_n = 1'b0;
        end
    end

    assign pm_addr = pc;
    assign busy    = active;
    assign halted  = (state == HALT);

endmodule

// File: tb/tb_pm_fetch_sequencer.sv
// Self-checking bench for pm_fetch_sequencer: scoreboard of presented
// instructions plus per-scenario latency and status checks.
`timescale 1ns/1ps
module tb_pm_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] pm_addr;
    logic [7:0] pm_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_op;
    logic [7:0] instr_imm;
    logic [4:0] instr_pc;
    logic       redirect_valid;
    logic [4:0] redirect_addr;
    logic       busy;
    logic       halted;

    logic [7:0]  mem [32];
    logic [20:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;

    always #5 clk = ~clk;

    assign pm_data = mem[pm_addr];

    pm_fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .pm_addr        (pm_addr),
        .pm_data        (pm_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_op       (instr_op),
        .instr_imm      (instr_imm),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .busy           (busy),
        .halted         (halted)
    );

    // Scoreboard: every handshake must match the oldest expected instruction.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            logic [20:0] e;
            hs_count++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got op=%h imm=%h pc=%0d, required no transfer",
                         instr_op, instr_imm, instr_pc);
            end else begin
                e = sb_q.pop_front();
                if ({instr_op, instr_imm, instr_pc} !== e) begin
                    errors++;
                    $display("FAIL sb_instr: got op=%h imm=%h pc=%0d, required op=%h imm=%h pc=%0d",
                             instr_op, instr_imm, instr_pc, e[20:13], e[12:5], e[4:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!instr_valid && n < max);
        if (!instr_valid) n = 99;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        start          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 5'd0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h40 + 8'(i);
        sb_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic redirect_to(input logic [4:0] a);
        redirect_valid = 1'b1;
        redirect_addr  = a;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        pulse_start();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({instr_valid, instr_op, instr_imm, instr_pc, busy, halted, pm_addr} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b op=%h imm=%h pc=%0d busy=%b halt=%b addr=%0d, required all 0",
                     instr_valid, instr_op, instr_imm, instr_pc, busy, halted, pm_addr);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b halted=%b, required 0 0", busy, halted);
        end
    endtask

    task automatic test_one_byte();
        int n;
        do_reset();
        mem[0] = 8'h10;
        instr_ready = 1'b1;
        sb_q.push_back({8'h10, 8'h00, 5'd0});
        pulse_start();
        wait_valid(8, n);
        checks++;
        if (n + 1 !== 2) begin
            errors++;
            $display("FAIL one_byte_latency: got %0d, required 2", n + 1);
        end
        sb_q.push_back({8'h41, 8'h00, 5'd1});
        wait_valid(8, n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL one_byte_b2b: got %0d, required 2", n);
        end
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_two_byte();
        int n;
        do_reset();
        mem[9]  = 8'h20;
        mem[10] = 8'h09;
        mem[11] = 8'hA0;
        pulse_start();
        redirect_to(5'd9);
        checks++;
        if (pm_addr !== 5'd9) begin
            errors++;
            $display("FAIL two_byte_addr: got %0d, required 9", pm_addr);
        end
        wait_valid(8, n);
        checks++;
        if (n + 1 !== 3) begin
            errors++;
            $display("FAIL two_byte_latency: got %0d, required 3", n + 1);
        end
        sb_q.push_back({8'h20, 8'h09, 5'd9});
        sb_q.push_back({8'hA0, 8'h00, 5'd11});
        instr_ready = 1'b1;
        wait_valid(8, n);
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL two_byte_b2b: got %0d, required 2", n);
        end
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_stall();
        int n;
        int hs0;
        do_reset();
        pulse_start();
        wait_valid(8, n);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            start = 1'b0;
            checks++;
            if ({instr_valid, instr_op, instr_imm, instr_pc} !== {1'b1, 8'h40, 8'h00, 5'd0}) begin
                errors++;
                $display("FAIL stall_hold: got v=%b op=%h imm=%h pc=%0d, required v=1 op=40 imm=00 pc=0",
                         instr_valid, instr_op, instr_imm, instr_pc);
            end
        end
        hs0 = hs_count;
        sb_q.push_back({8'h40, 8'h00, 5'd0});
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drop: got valid=%b, required 0", instr_valid);
        end
        wait_valid(8, n);
        repeat (2) tick();
        checks++;
        if (hs_count - hs0 !== 1 || instr_pc !== 5'd1) begin
            errors++;
            $display("FAIL stall_single: got transfers=%0d pc=%0d, required 1 and 1",
                     hs_count - hs0, instr_pc);
        end
    endtask

    task automatic test_redirect_handshake();
        int n;
        do_reset();
        mem[23] = 8'hD0;
        mem[24] = 8'h15;
        mem[25] = 8'h77;
        mem[21] = 8'h33;
        pulse_start();
        redirect_to(5'd23);
        wait_valid(8, n);
        checks++;
        if (instr_pc !== 5'd23) begin
            errors++;
            $display("FAIL redir_present_pc: got %0d, required 23", instr_pc);
        end
        sb_q.push_back({8'hD0, 8'h15, 5'd23});
        sb_q.push_back({8'h33, 8'h00, 5'd21});
        instr_ready = 1'b1;
        redirect_to(5'd21);
        checks++;
        if (pm_addr !== 5'd21 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_apply: got addr=%0d valid=%b, required 21 0", pm_addr, instr_valid);
        end
        wait_valid(8, n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL redir_latency: got %0d, required 1", n);
        end
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int n;
        do_reset();
        mem[31] = 8'h20;
        mem[0]  = 8'h05;
        pulse_start();
        redirect_to(5'd31);
        wait_valid(8, n);
        checks++;
        if (pm_addr !== 5'd1) begin
            errors++;
            $display("FAIL wrap_next_addr: got %0d, required 1", pm_addr);
        end
        sb_q.push_back({8'h20, 8'h05, 5'd31});
        sb_q.push_back({8'h41, 8'h00, 5'd1});
        instr_ready = 1'b1;
        wait_valid(8, n);
        checks++;
        if (n !== 2 || instr_pc !== 5'd1) begin
            errors++;
            $display("FAIL wrap_follow: got lat=%0d pc=%0d, required 2 1", n, instr_pc);
        end
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_halt();
        int n;
        do_reset();
        mem[30] = 8'h00;
        instr_ready = 1'b1;
        pulse_start();
        redirect_to(5'd30);
        tick();
        checks++;
        if ({halted, busy, instr_valid, pm_addr} !== {1'b1, 1'b0, 1'b0, 5'd31}) begin
            errors++;
            $display("FAIL halt_enter: got halt=%b busy=%b valid=%b addr=%0d, required 1 0 0 31",
                     halted, busy, instr_valid, pm_addr);
        end
        redirect_to(5'd5);
        tick();
        checks++;
        if (halted !== 1'b1 || pm_addr !== 5'd31) begin
            errors++;
            $display("FAIL halt_redirect: got halt=%b addr=%0d, required 1 31", halted, pm_addr);
        end
        sb_q.push_back({8'h40, 8'h00, 5'd0});
        start          = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 5'd5;
        tick();
        start          = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if ({pm_addr, busy, halted} !== {5'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL halt_restart: got addr=%0d busy=%b halt=%b, required 0 1 0",
                     pm_addr, busy, halted);
        end
        wait_valid(8, n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL halt_restart_lat: got %0d, required 1", n);
        end
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic test_reset_mid_imm();
        do_reset();
        mem[0] = 8'h2A;
        mem[1] = 8'h11;
        pulse_start();
        tick();
        checks++;
        if (busy !== 1'b1 || pm_addr !== 5'd1 || instr_op !== 8'h2A) begin
            errors++;
            $display("FAIL mid_imm_state: got busy=%b addr=%0d op=%h, required 1 1 2a",
                     busy, pm_addr, instr_op);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({instr_valid, instr_op, instr_imm, instr_pc, busy, halted, pm_addr} !== 30'd0) begin
            errors++;
            $display("FAIL mid_imm_reset: got v=%b op=%h imm=%h pc=%0d busy=%b halt=%b addr=%0d, required all 0",
                     instr_valid, instr_op, instr_imm, instr_pc, busy, halted, pm_addr);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_one_byte();
        test_two_byte();
        test_stall();
        test_redirect_handshake();
        test_wrap();
        test_halt();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending, required 0", sb_q.size());
        end
        test_reset_mid_imm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
